harmonic_scale_sequencer: RTL and testbench

//  Initiator side of the scale-multiplier handshake. For each output sample it restarts the scaler,

---
 rtl/harmonic_scale_sequencer.sv | 145 ++++++++++++++
 tb/tb_harmonic_scale_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_scale_sequencer.sv
// Purpose: per output sample, restarts the scaler and sums sine(h) * multiple(h) over harmonics 0..count-1.
// Latency: 4*count-ish cycles plus sine/scaler wait; a zero-harmonic request completes two edges after start.
// Backpressure: stalls indefinitely in REQ/WAIT_RDY until sine source and scaler respond; starts while busy are dropped and flagged.
//
// Ports:
//   i_Clock, i_Reset_N                 clock, asynchronous active-low reset
//   i_Sample_Start, i_Harmonic_Count   sample trigger and number of harmonics (latched on accept)
//   o_Sine_Req, o_Harmonic             sine fetch request / index; i_Sine, i_Sine_Valid answer it
//   o_Scale_Restart, o_Scale_Start     scaler control pulses; i_Mult, i_Mult_Ready from scaler
//   o_Sample, o_Sample_Valid           summed result and its update strobe
//   o_Busy, o_Overrun                  activity flag, dropped-start strobe
module harmonic_scale_sequencer #(
  parameter int DIV_BIT     = 11,
  parameter int SAMPLE_BITS = 16,
  parameter int HARM_BITS   = 8,
  parameter int ACC_BITS    = 36
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_N,
  input  logic                          i_Sample_Start,
  input  logic [HARM_BITS-1:0]          i_Harmonic_Count,
  output logic                          o_Sine_Req,
  output logic [HARM_BITS-1:0]          o_Harmonic,
  input  logic signed [SAMPLE_BITS-1:0] i_Sine,
  input  logic                          i_Sine_Valid,
  output logic                          o_Scale_Restart,
  output logic                          o_Scale_Start,
  input  logic [DIV_BIT-1:0]            i_Mult,
  input  logic                          i_Mult_Ready,
  output logic signed [ACC_BITS-1:0]    o_Sample,
  output logic                          o_Sample_Valid,
  output logic                          o_Busy,
  output logic                          o_Overrun
);

  localparam int PROD_W = SAMPLE_BITS + DIV_BIT + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_MAC,
    S_WAIT_LOW,
    S_WAIT_RDY,
    S_DONE
  } state_t;

  state_t                        state;
  logic [HARM_BITS-1:0]          count_q;
  logic signed [SAMPLE_BITS-1:0] sine_q;
  logic [DIV_BIT-1:0]            mult_q;
  logic signed [ACC_BITS-1:0]    acc;
  logic signed [PROD_W-1:0]      product;
  logic                          last_harm;

  // Restart must reach the scaler on the same edge that accepts the start,
  // so that the multiple seen in the first REQ cycle is already the initial one.
  assign o_Scale_Restart = i_Reset_N && (state == S_IDLE) && i_Sample_Start;

  // Multiple is unsigned: zero-extend by one bit before the signed multiply.
  assign product   = PROD_W'(sine_q) * PROD_W'($signed({1'b0, mult_q}));
  assign last_harm = (o_Harmonic == (count_q - HARM_BITS'(1)));

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state          <= S_IDLE;
      count_q        <= '0;
      sine_q         <= '0;
      mult_q         <= '0;
      acc            <= '0;
      o_Sine_Req     <= 1'b0;
      o_Harmonic     <= '0;
      o_Scale_Start  <= 1'b0;
      o_Sample       <= '0;
      o_Sample_Valid <= 1'b0;
      o_Busy         <= 1'b0;
      o_Overrun      <= 1'b0;
    end else begin
      o_Scale_Start  <= 1'b0;
      o_Sample_Valid <= 1'b0;
      o_Overrun      <= (state != S_IDLE) && i_Sample_Start;

      case (state)
        S_IDLE: begin
          // Busy stays high through the cycle that shows o_Sample_Valid and
          // drops on the following edge unless a new sample is accepted.
          o_Busy <= i_Sample_Start;
          if (i_Sample_Start) begin
            count_q    <= i_Harmonic_Count;
            acc        <= '0;
            o_Harmonic <= '0;
            if (i_Harmonic_Count == '0) begin
              state <= S_DONE;
            end else begin
              state      <= S_REQ;
              o_Sine_Req <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (i_Sine_Valid && i_Mult_Ready) begin
            sine_q     <= i_Sine;
            mult_q     <= i_Mult;
            o_Sine_Req <= 1'b0;
            state      <= S_MAC;
          end
        end

        S_MAC: begin
          acc <= acc + ACC_BITS'(product);
          if (last_harm) begin
            state <= S_DONE;
          end else begin
            o_Harmonic    <= o_Harmonic + HARM_BITS'(1);
            o_Scale_Start <= 1'b1;
            state         <= S_WAIT_LOW;
          end
        end

        // The scaler only drops ready after it has seen the start pulse,
        // so ready is not trusted for this one cycle.
        S_WAIT_LOW: state <= S_WAIT_RDY;

        S_WAIT_RDY: begin
          if (i_Mult_Ready) begin
            state      <= S_REQ;
            o_Sine_Req <= 1'b1;
          end
        end

        S_DONE: begin
          o_Sample       <= acc;
          o_Sample_Valid <= 1'b1;
          state          <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          o_Sine_Req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_scale_sequencer.sv
// Purpose: randomized bench for harmonic_scale_sequencer with behavioural scaler and sine source.
// Latency: n/a (testbench).
// Backpressure: sine source inserts random wait states; scaler drops ready for one cycle per step.
module tb_harmonic_scale_sequencer;

  logic               clk;
  logic               rst_n;
  logic               i_Sample_Start;
  logic [7:0]         i_Harmonic_Count;
  logic               o_Sine_Req;
  logic [7:0]         o_Harmonic;
  logic signed [15:0] i_Sine;
  logic               i_Sine_Valid;
  logic               o_Scale_Restart;
  logic               o_Scale_Start;
  logic [10:0]        i_Mult;
  logic               i_Mult_Ready;
  logic signed [35:0] o_Sample;
  logic               o_Sample_Valid;
  logic               o_Busy;
  logic               o_Overrun;

  harmonic_scale_sequencer dut (
    .i_Clock          (clk),
    .i_Reset_N        (rst_n),
    .i_Sample_Start   (i_Sample_Start),
    .i_Harmonic_Count (i_Harmonic_Count),
    .o_Sine_Req       (o_Sine_Req),
    .o_Harmonic       (o_Harmonic),
    .i_Sine           (i_Sine),
    .i_Sine_Valid     (i_Sine_Valid),
    .o_Scale_Restart  (o_Scale_Restart),
    .o_Scale_Start    (o_Scale_Start),
    .i_Mult           (i_Mult),
    .i_Mult_Ready     (i_Mult_Ready),
    .o_Sample         (o_Sample),
    .o_Sample_Valid   (o_Sample_Valid),
    .o_Busy           (o_Busy),
    .o_Overrun        (o_Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int sine_tab [0:255];
  int init_v   = 0;
  int scale_v  = 0;
  int max_wait = 0;
  bit noise_en = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural scaler: restart loads INIT, each start subtracts SCALE
  // (floored at 0) and drops ready for exactly one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_Mult       <= '0;
      i_Mult_Ready <= 1'b1;
    end else begin
      i_Mult_Ready <= 1'b1;
      if (o_Scale_Restart) begin
        i_Mult <= 11'(init_v);
      end else if (o_Scale_Start) begin
        i_Mult       <= (int'(i_Mult) > scale_v) ? i_Mult - 11'(scale_v) : 11'd0;
        i_Mult_Ready <= 1'b0;
      end
    end
  end

  // Sine source: answers requests after a random 0..max_wait cycle delay;
  // drives random junk on valid while no request is pending.
  int  wait_left;
  logic noise;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_left <= 0;
      noise     <= 1'b0;
    end else begin
      noise <= noise_en && ($urandom_range(0, 1) == 1);
      if (o_Sine_Req && i_Sine_Valid)
        wait_left <= int'($urandom_range(0, max_wait));
      else if (o_Sine_Req && wait_left != 0)
        wait_left <= wait_left - 1;
    end
  end
  assign i_Sine_Valid = o_Sine_Req ? (wait_left == 0) : noise;
  assign i_Sine       = 16'(sine_tab[o_Harmonic]);

  // Cumulative event monitor; runs compare differences of these counters.
  int restart_cnt = 0, start_cnt = 0, ovr_cnt = 0, valid_cnt = 0;
  int req_cnt = 0, harm_err = 0, starts_since_restart = 0;
  always @(negedge clk) begin
    if (o_Scale_Restart) begin
      restart_cnt++;
      starts_since_restart = 0;
    end
    if (o_Scale_Start) begin
      start_cnt++;
      starts_since_restart++;
    end
    if (o_Overrun)      ovr_cnt++;
    if (o_Sample_Valid) valid_cnt++;
    if (o_Sine_Req) begin
      req_cnt++;
      if (int'(o_Harmonic) != starts_since_restart) harm_err++;
    end
  end

  function automatic longint model(input int cnt, input int init, input int scale);
    longint s = 0;
    int m = init;
    for (int k = 0; k < cnt; k++) begin
      s += longint'(sine_tab[k]) * longint'(m);
      m = (m > scale) ? m - scale : 0;
    end
    return s;
  endfunction

  task automatic fill_const(input int v);
    for (int k = 0; k < 256; k++) sine_tab[k] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 256; k++) sine_tab[k] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic run_sample(input string tag, input int cnt, input int init, input int scale,
                            input int maxw, input int repulse);
    longint exp_v;
    int b_rst, b_st, b_ovr, b_val, b_req, b_herr;
    int cyc;
    bit got_v;
    exp_v    = model(cnt, init, scale);
    init_v   = init;
    scale_v  = scale;
    max_wait = maxw;
    @(posedge clk); #1;
    b_rst = restart_cnt; b_st = start_cnt; b_ovr = ovr_cnt;
    b_val = valid_cnt;   b_req = req_cnt;  b_herr = harm_err;
    i_Sample_Start   = 1'b1;
    i_Harmonic_Count = 8'(cnt);
    @(posedge clk); #1;
    i_Sample_Start   = 1'b0;
    i_Harmonic_Count = 8'($urandom_range(0, 255));
    cyc   = 0;
    got_v = 1'b0;
    while (cyc < 5000 && !got_v) begin
      @(negedge clk);
      cyc++;
      i_Sample_Start = (repulse != 0 && cyc == repulse);
      if (o_Sample_Valid) begin
        got_v = 1'b1;
        chk({tag, "_sample"}, longint'(o_Sample), exp_v);
        chk({tag, "_busy_at_valid"}, longint'(o_Busy), 1);
      end
    end
    i_Sample_Start = 1'b0;
    if (!got_v) chk({tag, "_timeout"}, 0, 1);
    if (cnt == 0) chk({tag, "_latency"}, cyc, 2);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_after"}, longint'(o_Busy), 0);
    chk({tag, "_valid_pulses"}, valid_cnt - b_val, 1);
    chk({tag, "_restarts"}, restart_cnt - b_rst, 1);
    chk({tag, "_starts"}, start_cnt - b_st, (cnt > 0) ? cnt - 1 : 0);
    chk({tag, "_overrun"}, ovr_cnt - b_ovr, (repulse != 0) ? 1 : 0);
    chk({tag, "_req_seen"}, (req_cnt - b_req) > 0, cnt > 0);
    chk({tag, "_harm_walk"}, harm_err - b_herr, 0);
  endtask

  initial begin
    int found, cyc, b_val;
    rst_n            = 1'b0;
    i_Sample_Start   = 1'b0;
    i_Harmonic_Count = '0;
    fill_const(0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample", longint'(o_Sample), 0);
    chk("rst_valid", longint'(o_Sample_Valid), 0);
    chk("rst_busy", longint'(o_Busy), 0);
    chk("rst_req", longint'(o_Sine_Req), 0);
    chk("rst_harm", longint'(o_Harmonic), 0);
    chk("rst_sstart", longint'(o_Scale_Start), 0);
    chk("rst_overrun", longint'(o_Overrun), 0);
    chk("rst_restart", longint'(o_Scale_Restart), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill_const(1000);
    run_sample("t1", 1, 2047, 0, 0, 0);
    fill_const(100);
    run_sample("t2", 3, 1000, 300, 0, 0);
    run_sample("t3", 0, 1000, 300, 0, 0);
    fill_const(-32768);
    run_sample("t4a", 255, 2047, 0, 0, 0);
    run_sample("t4b", 255, 2047, 0, 5, 0);
    fill_const(100);
    run_sample("t5", 3, 1000, 300, 0, 4);

    // Reset while harmonic 2 is being accumulated.
    init_v   = 1000;
    scale_v  = 300;
    max_wait = 0;
    @(posedge clk); #1;
    i_Sample_Start   = 1'b1;
    i_Harmonic_Count = 8'd3;
    @(posedge clk); #1;
    i_Sample_Start = 1'b0;
    found = 0;
    cyc   = 0;
    while (cyc < 200 && found == 0) begin
      @(negedge clk);
      cyc++;
      if (o_Harmonic == 8'd2 && o_Sine_Req && i_Sine_Valid) found = 1;
    end
    chk("t6_reach_h2", found, 1);
    b_val = valid_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_sample", longint'(o_Sample), 0);
    chk("t6_valid", longint'(o_Sample_Valid), 0);
    chk("t6_busy", longint'(o_Busy), 0);
    chk("t6_req", longint'(o_Sine_Req), 0);
    chk("t6_harm", longint'(o_Harmonic), 0);
    chk("t6_sstart", longint'(o_Scale_Start), 0);
    repeat (3) @(negedge clk);
    chk("t6_no_valid", valid_cnt - b_val, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_const(5);
    run_sample("t6b", 1, 10, 0, 0, 0);

    noise_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fill_rand();
      run_sample($sformatf("rnd%0d", i), int'($urandom_range(0, 24)), int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 300)), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 1) == 1) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
